// File: rtl/memory_access_sequencer.sv
// -----------------------------------------------------------------------------
// memory_access_sequencer
//
// Turns host burst read/write requests (already decoded from SPI) into a
// stream of single-message program_memory_new / read_memory_sync pulses for
// the per-memory managers.
//
// Before touching memory it asks the compute core to stay off the memories
// (core_hold_o). It then waits until the core reports it is idle
// (core_busy_i low). After that it walks the burst with an auto-incrementing
// message address.
//
// Ports
//   clk_i, rst_ni             clock (rising edge), synchronous active-low reset
//   req_valid_i/req_ready_o   burst request handshake
//   req_write_i               1 = write burst, 0 = read burst
//   req_code_i                target memory code
//   req_address_i             start message address
//   req_length_i              messages in burst minus one
//   wdata_valid_i/_ready_o    write message handshake, payload wdata_i
//   rdata_valid_o/_ready_i    read message handshake, payload rdata_o
//   core_busy_i/core_hold_o   arbitration with the compute core
//   program_memory_new_o      one-cycle write pulse to the memory managers
//   read_memory_sync_o        one-cycle read pulse to the memory managers
//   memory_code_o             selected memory code
//   spi_address_o             current message address
//   spi_data_in_o             registered write message
//   spi_data_out_i            read data muxed back from the selected manager
//   busy_o                    high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module memory_access_sequencer #(
    parameter int MESSAGE_BIT_WIDTH       = 32,
    parameter int START_ADDRESS_BIT_WIDTH = 14,
    parameter int CODE_BIT_WIDTH          = 4,
    parameter int BURST_BIT_WIDTH         = 8,
    parameter int READ_LATENCY            = 1
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               req_valid_i,
    output logic                               req_ready_o,
    input  logic                               req_write_i,
    input  logic [CODE_BIT_WIDTH-1:0]          req_code_i,
    input  logic [START_ADDRESS_BIT_WIDTH-1:0] req_address_i,
    input  logic [BURST_BIT_WIDTH-1:0]         req_length_i,
    input  logic                               wdata_valid_i,
    output logic                               wdata_ready_o,
    input  logic [MESSAGE_BIT_WIDTH-1:0]       wdata_i,
    output logic                               rdata_valid_o,
    input  logic                               rdata_ready_i,
    output logic [MESSAGE_BIT_WIDTH-1:0]       rdata_o,
    input  logic                               core_busy_i,
    output logic                               core_hold_o,
    output logic                               program_memory_new_o,
    output logic                               read_memory_sync_o,
    output logic [CODE_BIT_WIDTH-1:0]          memory_code_o,
    output logic [START_ADDRESS_BIT_WIDTH-1:0] spi_address_o,
    output logic [MESSAGE_BIT_WIDTH-1:0]       spi_data_in_o,
    input  logic [MESSAGE_BIT_WIDTH-1:0]       spi_data_out_i,
    output logic                               busy_o
);

    // The latency counter only has to reach READ_LATENCY-1.
    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACQUIRE,
        ST_WAIT_DATA,
        ST_PROGRAM,
        ST_READ,
        ST_READ_WAIT,
        ST_RESPOND
    } state_e;

    state_e                               state_q, state_d;
    logic                                 write_q, write_d;
    logic [CODE_BIT_WIDTH-1:0]            code_q, code_d;
    logic [START_ADDRESS_BIT_WIDTH-1:0]   addr_q, addr_d;
    logic [BURST_BIT_WIDTH-1:0]           remain_q, remain_d;
    logic [MESSAGE_BIT_WIDTH-1:0]         wdata_q, wdata_d;
    logic [MESSAGE_BIT_WIDTH-1:0]         rdata_q, rdata_d;
    logic [LAT_W-1:0]                     lat_cnt_q, lat_cnt_d;

    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        code_d    = code_q;
        addr_d    = addr_q;
        remain_d  = remain_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        lat_cnt_d = lat_cnt_q;

        req_ready_o          = 1'b0;
        wdata_ready_o        = 1'b0;
        rdata_valid_o        = 1'b0;
        program_memory_new_o = 1'b0;
        read_memory_sync_o   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    write_d  = req_write_i;
                    code_d   = req_code_i;
                    addr_d   = req_address_i;
                    remain_d = req_length_i;
                    state_d  = ST_ACQUIRE;
                end
            end

            // core_hold is already up; proceed once the core has drained.
            ST_ACQUIRE: begin
                if (!core_busy_i) begin
                    state_d = write_q ? ST_WAIT_DATA : ST_READ;
                end
            end

            ST_WAIT_DATA: begin
                wdata_ready_o = 1'b1;
                if (wdata_valid_i) begin
                    wdata_d = wdata_i;
                    state_d = ST_PROGRAM;
                end
            end

            // Address/code stay put during the pulse and advance afterwards;
            // the address wraps naturally at the register width.
            ST_PROGRAM: begin
                program_memory_new_o = 1'b1;
                addr_d   = addr_q + START_ADDRESS_BIT_WIDTH'(1);
                remain_d = remain_q - BURST_BIT_WIDTH'(1);
                state_d  = (remain_q == '0) ? ST_IDLE : ST_WAIT_DATA;
            end

            ST_READ: begin
                read_memory_sync_o = 1'b1;
                lat_cnt_d = '0;
                state_d   = ST_READ_WAIT;
            end

            // Capture on the last latency cycle so rdata_valid rises exactly
            // READ_LATENCY+1 cycles after the read pulse.
            ST_READ_WAIT: begin
                if (lat_cnt_q == LAT_LAST) begin
                    rdata_d = spi_data_out_i;
                    state_d = ST_RESPOND;
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end

            ST_RESPOND: begin
                rdata_valid_o = 1'b1;
                if (rdata_ready_i) begin
                    addr_d   = addr_q + START_ADDRESS_BIT_WIDTH'(1);
                    remain_d = remain_q - BURST_BIT_WIDTH'(1);
                    state_d  = (remain_q == '0) ? ST_IDLE : ST_READ;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Handshakes and pulses are suppressed for the whole time reset is
        // held, not only from the reset edge onwards.
        if (!rst_ni) begin
            req_ready_o          = 1'b0;
            wdata_ready_o        = 1'b0;
            rdata_valid_o        = 1'b0;
            program_memory_new_o = 1'b0;
            read_memory_sync_o   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            write_q   <= 1'b0;
            code_q    <= '0;
            addr_q    <= '0;
            remain_q  <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            lat_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            code_q    <= code_d;
            addr_q    <= addr_d;
            remain_q  <= remain_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    assign busy_o        = (state_q != ST_IDLE);
    assign core_hold_o   = rst_ni && (state_q != ST_IDLE);
    assign memory_code_o = code_q;
    assign spi_address_o = addr_q;
    assign spi_data_in_o = wdata_q;
    assign rdata_o       = rdata_q;

endmodule
